// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//   Two-master / one-slave Wishbone classic arbiter with a bus-timeout
//   watchdog. Master 0 is the CPU, master 1 an auxiliary master (DMA, loader).
//   Grants round-robin, holds the grant for the whole cycle, and terminates a
//   hung slave cycle with an error-ack while recording a sticky fault.
//
// Parameters
//   TIMEOUT  : slave ack deadline in BUSY cycles, 0 disables the watchdog
//   ERR_DATA : read data returned to the master on a timed-out cycle
//
// Ports
//   wb_clk, wb_rst_n        : clock, asynchronous active-low reset
//   m{0,1}_adr/dat/sel/we   : master request payload
//   m{0,1}_cyc              : master cycle request
//   m{0,1}_rdt, m{0,1}_ack  : read data and acknowledge back to each master
//   s_adr/dat/sel/we        : payload of the granted master towards the slave
//   s_cyc, s_stb            : slave cycle / strobe (always equal)
//   s_rdt, s_ack            : slave read data and acknowledge
//   err_clr                 : clears the sticky timeout flag
//   err_flag, err_adr,
//   err_mst                 : sticky timeout flag, faulting address, master id
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,

  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_cyc,
  output logic [31:0] m0_rdt,
  output logic        m0_ack,

  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  output logic [31:0] m1_rdt,
  output logic        m1_ack,

  output logic [31:0] s_adr,
  output logic [31:0] s_dat,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic [31:0] s_rdt,
  input  logic        s_ack,

  input  logic        err_clr,
  output logic        err_flag,
  output logic [31:0] err_adr,
  output logic        err_mst
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Counter value of the last BUSY cycle before the watchdog fires
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic [AW-1:0]    err_adr_q, err_adr_d;
  logic             err_mst_q, err_mst_d;

  // Payload of the currently granted master
  logic             g_cyc;
  logic [AW-1:0]    g_adr;
  logic [DW-1:0]    g_dat;
  logic [SW-1:0]    g_sel;
  logic             g_we;

  logic             busy;
  logic             done_ok;
  logic             done_to;
  logic             done_any;

  // Grant mux
  always_comb begin
    g_cyc = m0_cyc;
    g_adr = m0_adr;
    g_dat = m0_dat;
    g_sel = m0_sel;
    g_we  = m0_we;
    if (gnt_q) begin
      g_cyc = m1_cyc;
      g_adr = m1_adr;
      g_dat = m1_dat;
      g_sel = m1_sel;
      g_we  = m1_we;
    end
  end

  // Cycle termination decode; a slave ack in the deadline cycle wins
  always_comb begin
    busy     = (state_q == ST_BUSY);
    done_ok  = busy && g_cyc && s_ack;
    done_to  = busy && g_cyc && !s_ack && WDOG_EN && (cnt_q == CNT_LAST);
    done_any = done_ok || done_to;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    err_adr_d  = err_adr_q;
    err_mst_d  = err_mst_q;

    if (err_clr) begin
      err_flag_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Counter is held at zero so it starts clean on entry to BUSY
        cnt_d = '0;
        if (m0_cyc || m1_cyc) begin
          state_d = ST_BUSY;
          // On contention the master that did not win last time goes first
          gnt_d   = (m0_cyc && m1_cyc) ? ~last_q : m1_cyc;
        end
      end

      ST_BUSY: begin
        if (!g_cyc) begin
          // Master abandoned the cycle: no ack, fairness history untouched
          state_d = ST_IDLE;
        end else if (s_ack) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end else if (done_to) begin
          // A new timeout overrides a simultaneous err_clr
          state_d    = ST_IDLE;
          last_d     = gnt_q;
          err_flag_d = 1'b1;
          err_adr_d  = g_adr;
          err_mst_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and error registers
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      err_adr_q  <= '0;
      err_mst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      err_adr_q  <= err_adr_d;
      err_mst_q  <= err_mst_d;
    end
  end

  // Slave side: the cycle is withdrawn in the cycle the watchdog fires
  always_comb begin
    s_adr = g_adr;
    s_dat = g_dat;
    s_sel = g_sel;
    s_we  = g_we;
    s_cyc = busy && g_cyc && !done_to;
    s_stb = s_cyc;
  end

  // Master side: read data is a shared bus except on a watchdog error-ack
  always_comb begin
    m0_ack = done_any && !gnt_q;
    m1_ack = done_any &&  gnt_q;
    m0_rdt = (done_to && !gnt_q) ? ERR_DATA : s_rdt;
    m1_rdt = (done_to &&  gnt_q) ? ERR_DATA : s_rdt;
  end

  assign err_flag = err_flag_q;
  assign err_adr  = err_adr_q;
  assign err_mst  = err_mst_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter (TIMEOUT=8). Expected acks are queued when
//   the slave response is driven and retired when a master ack is sampled.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [31:0] s_rdt;
  logic        s_ack;
  logic        err_clr;
  logic        err_flag;
  logic [31:0] err_adr;
  logic        err_mst;

  typedef struct packed {
    logic        mst;
    logic [31:0] rdt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  wb_rr_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .wb_clk  (wb_clk),  .wb_rst_n(wb_rst_n),
    .m0_adr  (m0_adr),  .m0_dat  (m0_dat),  .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc  (m0_cyc),  .m0_rdt  (m0_rdt),  .m0_ack(m0_ack),
    .m1_adr  (m1_adr),  .m1_dat  (m1_dat),  .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc  (m1_cyc),  .m1_rdt  (m1_rdt),  .m1_ack(m1_ack),
    .s_adr   (s_adr),   .s_dat   (s_dat),   .s_sel (s_sel),  .s_we (s_we),
    .s_cyc   (s_cyc),   .s_stb   (s_stb),   .s_rdt (s_rdt),  .s_ack(s_ack),
    .err_clr (err_clr), .err_flag(err_flag),
    .err_adr (err_adr), .err_mst (err_mst)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire one scoreboard entry per sampled ack
  task automatic observe();
    exp_t e;
    if (m0_ack || m1_ack) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_onehot", {30'd0, m1_ack, m0_ack}, e.mst ? 32'd2 : 32'd1);
        chk("ack_rdt", e.mst ? m1_rdt : m0_rdt, e.rdt);
      end
    end
  endtask

  task automatic sample();
    @(negedge wb_clk);
    observe();
  endtask

  task automatic adv();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic push(input logic mst, input logic [31:0] rdt);
    exp_t e;
    e.mst = mst;
    e.rdt = rdt;
    sb.push_back(e);
  endtask

  // Single-master transaction from IDLE; ack_at=0 means the slave never acks
  task automatic txn(input logic mst, input logic [31:0] adr, input logic we,
                     input int ack_at, input logic [31:0] rdt, input logic clr_last);
    if (mst) begin
      m1_adr = adr; m1_dat = ~adr; m1_we = we; m1_cyc = 1'b1;
    end else begin
      m0_adr = adr; m0_dat = ~adr; m0_we = we; m0_cyc = 1'b1;
    end
    sample();
    chk("idle_s_cyc", 32'(s_cyc), 32'd0);
    adv();
    for (int b = 1; b <= int'(TO); b++) begin
      s_ack   = (b == ack_at);
      s_rdt   = rdt;
      err_clr = clr_last && (b == int'(TO));
      if (b == ack_at) push(mst, rdt);
      else if (b == int'(TO)) push(mst, ERR);
      sample();
      if (b == int'(TO) && b != ack_at) begin
        chk("to_s_cyc", 32'(s_cyc), 32'd0);
      end else begin
        chk("busy_s_cyc", 32'(s_cyc), 32'd1);
        chk("busy_s_adr", s_adr, adr);
        chk("busy_s_we", 32'(s_we), 32'(we));
      end
      adv();
      if (b == ack_at) break;
    end
    s_ack = 1'b0; err_clr = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wb_rst_n = 1'b0;
    m0_adr = '0; m0_dat = '0; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = 4'hF; m1_we = 1'b0; m1_cyc = 1'b0;
    s_rdt = '0; s_ack = 1'b0; err_clr = 1'b0;

    // Reset values
    #12;
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_adr", err_adr, 32'd0);
    chk("rst_err_mst", 32'(err_mst), 32'd0);
    adv();
    wb_rst_n = 1'b1;

    // m0 read, slave acks in the third BUSY cycle
    txn(1'b0, 32'h1000_0004, 1'b0, 3, 32'h1234_5678, 1'b0);
    sample();
    chk("post_ack_m0", 32'(m0_ack), 32'd0);
    chk("post_ack_s_cyc", 32'(s_cyc), 32'd0);
    adv();

    // Fresh reset, then both masters contend and stay requesting
    wb_rst_n = 1'b0;
    adv();
    wb_rst_n = 1'b1;
    m0_adr = 32'h1000_0100; m1_adr = 32'h2000_0200;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("rr_idle_s_cyc", 32'(s_cyc), 32'd0);
      adv();
      s_ack = 1'b0;
      sample();
      chk("rr_s_cyc", 32'(s_cyc), 32'd1);
      chk("rr_grant", s_adr, (k % 2 == 1) ? 32'h2000_0200 : 32'h1000_0100);
      adv();
      s_ack = 1'b1;
      s_rdt = 32'hA000_0000 + 32'(k);
      push(1'(k % 2), s_rdt);
      sample();
      adv();
      s_ack = 1'b0;
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    chk("rr_sb_drain", 32'(sb.size()), 32'd0);

    // m1 write to a slave that never acks
    txn(1'b1, 32'h4000_0010, 1'b1, 0, 32'h0, 1'b0);
    sample();
    chk("to_err_flag", 32'(err_flag), 32'd1);
    chk("to_err_adr", err_adr, 32'h4000_0010);
    chk("to_err_mst", 32'(err_mst), 32'd1);
    adv();

    // err_clr on its own
    err_clr = 1'b1;
    adv();
    err_clr = 1'b0;
    sample();
    chk("clr_err_flag", 32'(err_flag), 32'd0);
    adv();

    // Slave ack exactly in the deadline cycle completes normally
    txn(1'b0, 32'h5000_0020, 1'b0, int'(TO), 32'hCAFE_0001, 1'b0);
    sample();
    chk("deadline_err_flag", 32'(err_flag), 32'd0);
    adv();

    // Timeout from m0, then a timeout from m1 racing an err_clr
    txn(1'b0, 32'h6000_0030, 1'b0, 0, 32'h0, 1'b0);
    sample();
    chk("to2_err_flag", 32'(err_flag), 32'd1);
    chk("to2_err_adr", err_adr, 32'h6000_0030);
    chk("to2_err_mst", 32'(err_mst), 32'd0);
    adv();
    txn(1'b1, 32'h7000_0040, 1'b1, 0, 32'h0, 1'b1);
    sample();
    chk("to3_err_flag", 32'(err_flag), 32'd1);
    chk("to3_err_adr", err_adr, 32'h7000_0040);
    chk("to3_err_mst", 32'(err_mst), 32'd1);
    adv();

    // Asynchronous reset in the middle of an m0 cycle
    m0_adr = 32'h8000_0000; m0_we = 1'b0; m0_cyc = 1'b1;
    sample();
    adv();
    sample();
    chk("pre_rst_s_cyc", 32'(s_cyc), 32'd1);
    adv();
    s_ack = 1'b1;
    s_rdt = 32'h0BAD_0BAD;
    wb_rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", 32'(s_cyc), 32'd0);
    chk("arst_m0_ack", 32'(m0_ack), 32'd0);
    chk("arst_err_flag", 32'(err_flag), 32'd0);
    chk("arst_err_adr", err_adr, 32'd0);
    chk("arst_err_mst", 32'(err_mst), 32'd0);
    s_ack = 1'b0;
    m1_adr = 32'h9000_0000; m1_we = 1'b0; m1_cyc = 1'b1;
    adv();
    wb_rst_n = 1'b1;
    sample();
    chk("arst_idle_s_cyc", 32'(s_cyc), 32'd0);
    adv();
    sample();
    chk("arst_first_grant", s_adr, 32'h8000_0000);
    chk("arst_flag_after", 32'(err_flag), 32'd0);
    adv();
    s_ack = 1'b1;
    s_rdt = 32'h1111_2222;
    push(1'b0, s_rdt);
    sample();
    adv();
    s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
    chk("arst_sb_drain", 32'(sb.size()), 32'd0);

    // m1 abandons its cycle; fairness history must not move
    m1_adr = 32'hC000_0000; m1_cyc = 1'b1;
    sample();
    adv();
    sample();
    chk("abort_busy_s_cyc", 32'(s_cyc), 32'd1);
    adv();
    m1_cyc = 1'b0;
    sample();
    chk("abort_s_cyc", 32'(s_cyc), 32'd0);
    chk("abort_m1_ack", 32'(m1_ack), 32'd0);
    adv();
    m0_adr = 32'hB000_0000;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    sample();
    chk("abort_idle_s_cyc", 32'(s_cyc), 32'd0);
    adv();
    sample();
    chk("abort_rr_grant", s_adr, 32'hC000_0000);
    adv();
    s_ack = 1'b1;
    s_rdt = 32'h3333_4444;
    push(1'b1, s_rdt);
    sample();
    adv();
    s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
    chk("abort_sb_drain", 32'(sb.size()), 32'd0);

    sample();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter with a bus-timeout watchdog.
- Shares the single CPU-side Wishbone port between the SERV CPU (master 0) and an auxiliary master such as a DMA or debug loader (master 1).
- Grants round-robin and holds the grant for a whole cycle.
- Terminates hung slave cycles with an error-ack and records a sticky fault for software.

Parameters:
- TIMEOUT, 255: slave ack deadline in BUSY cycles; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out cycle.

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- m0_adr, m1_adr  in  32  master address
- m0_dat, m1_dat  in  32  master write data
- m0_sel, m1_sel  in  4  byte selects
- m0_we, m1_we  in  1  write enable
- m0_cyc, m1_cyc  in  1  cycle request
- m0_rdt, m1_rdt  out  32  read data to master
- m0_ack, m1_ack  out  1  cycle acknowledge
- s_adr  out  32  slave address
- s_dat  out  32  slave write data
- s_sel  out  4  slave byte selects
- s_we  out  1  slave write enable
- s_cyc  out  1  slave cycle
- s_stb  out  1  slave strobe, equal to s_cyc
- s_rdt  in  32  slave read data
- s_ack  in  1  slave acknowledge
- err_clr  in  1  clears the sticky error
- err_flag  out  1  sticky timeout flag
- err_adr  out  32  address of the timed-out cycle
- err_mst  out  1  master id of the timed-out cycle

Behaviour:
- Reset (async, wb_rst_n=0): state=IDLE, last=1 (so m0 wins first), timeout counter=0, err_flag=0, err_adr=0, err_mst=0. All ack outputs and s_cyc read 0 while reset is held.
- Reset asserted mid-cycle: the slave cycle aborts immediately, no ack is issued, and the error state is cleared.
- FSM states: IDLE, BUSY.
- IDLE:
  - Both cyc low: stay in IDLE.
  - Exactly one cyc high: grant that master.
  - Both cyc high: grant the master that is not `last`.
  - On a grant: latch `gnt` and move to BUSY on the next edge. The cycle after the request is seen is the one-cycle arbitration latency.
- BUSY:
  - s_adr, s_dat, s_sel and s_we are combinationally muxed from master `gnt`. s_cyc = s_stb = the cyc of master `gnt`.
  - s_ack=1: pulse ack to master `gnt` for that cycle with rdt=s_rdt. Set last=gnt and go to IDLE.
  - Master `gnt` drops cyc before ack (abort): go to IDLE, issue no ack, leave `last` unchanged.
- Masters must drop cyc in the cycle after ack; IDLE re-arbitrates on the following edge.
- Non-granted master: ack=0 at all times. rdt is don't-care but is driven equal to s_rdt (shared bus).
- In IDLE: s_cyc=0, slave outputs are don't-care, and no ack is issued.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to BUSY and increments on every BUSY cycle without s_ack.
  - When the counter equals TIMEOUT-1 and s_ack=0, the arbiter acks master `gnt` itself with rdt=ERR_DATA.
  - In that same cycle s_cyc is forced to 0.
  - On the same edge: err_flag<=1, err_adr<=s_adr, err_mst<=gnt, last<=gnt, go to IDLE.
  - s_ack in the deadline cycle wins: normal completion, no error.
- Error register:
  - Each subsequent timeout overwrites err_adr and err_mst.
  - err_clr clears err_flag on the next edge.
  - A new timeout in the same cycle as err_clr wins: flag stays 1 and the fields update.
- TIMEOUT=0: the counter never fires, so BUSY may persist indefinitely.

Test Plan:
- m0 read only, slave acks 2 cycles after s_cyc with s_rdt=32'h1234_5678 -> m0_ack one pulse, m0_rdt=32'h1234_5678, m1_ack=0, s_adr=m0_adr throughout BUSY.
- m0 and m1 assert cyc in the same cycle from reset, both held after each ack, 4 transactions -> grant order m0, m1, m0, m1; s_cyc low for exactly one IDLE cycle between transactions.
- TIMEOUT=8, m1 write to adr 32'h4000_0010, slave never acks -> m1_ack in the 8th BUSY cycle with m1_rdt=32'hDEAD_BEEF, s_cyc=0 that cycle, err_flag=1, err_adr=32'h4000_0010, err_mst=1.
- TIMEOUT=8, slave acks exactly in the 8th BUSY cycle -> normal ack with s_rdt, err_flag stays 0; then err_clr pulse with a simultaneous second timeout -> err_flag remains 1 with the new err_adr.
- m0 in BUSY, wb_rst_n pulsed low mid-cycle -> s_cyc and m0_ack drop asynchronously; after release, m0 is granted first and err_flag=0.
- m1 drops cyc while in BUSY with no s_ack -> no ack, return to IDLE; the next simultaneous request still goes round-robin from the unchanged `last`.
